// File: rtl/decompress_word_writer.sv
// rtl/decompress_word_writer.sv - packs decoded bytes little-endian into 32-bit words for the output RAM
module decompress_word_writer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;

  // lane counts 0..4; it only reaches 4 after the top lane fills, on the way into WRITE
  logic [2:0]            lane;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wbuf;
  logic [3:0]            be;
  logic [ADDR_WIDTH:0]   wcount;

  logic                  restart;
  logic                  take;
  logic                  lone_last;
  logic                  wr_done;

  assign restart   = ((state == IDLE) || (state == DONE)) && start;
  assign take      = (state == FILL) && byte_valid;
  assign lone_last = (state == FILL) && !byte_valid && byte_last;
  assign wr_done   = (state == WRITE) && mem_ack;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = FILL;
      end
      FILL: begin
        if (byte_valid) begin
          if ((lane == 3'd3) || byte_last) state_nx = WRITE;
        end else if (byte_last) begin
          // an end marker with nothing buffered has no word to flush
          state_nx = (lane != 3'd0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (mem_ack) state_nx = flush ? DONE : FILL;
      end
      DONE: begin
        if (start) state_nx = FILL;
      end
      default: state_nx = IDLE;
    endcase
  end

  // word buffer, byte enables, address and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lane   <= 3'd0;
      flush  <= 1'b0;
      addr   <= '0;
      wbuf   <= 32'd0;
      be     <= 4'd0;
      wcount <= '0;
    end else if (restart) begin
      lane   <= 3'd0;
      flush  <= 1'b0;
      addr   <= BASE_ADDR;
      wbuf   <= 32'd0;
      be     <= 4'd0;
      wcount <= '0;
    end else if (take) begin
      wbuf[{lane[1:0], 3'b000} +: 8] <= byte_in;
      be[lane[1:0]]                  <= 1'b1;
      lane                           <= lane + 3'd1;
      flush                          <= byte_last;
    end else if (lone_last && (lane != 3'd0)) begin
      flush <= 1'b1;
    end else if (wr_done) begin
      // buffer is cleared so unused lanes of the next word read as zero
      addr   <= addr + ADDR_WIDTH'(1);
      wcount <= wcount + (ADDR_WIDTH + 1)'(1);
      wbuf   <= 32'd0;
      be     <= 4'd0;
      lane   <= 3'd0;
    end
  end

  assign byte_ready    = (state == FILL);
  assign mem_we        = (state == WRITE);
  assign mem_addr      = addr;
  assign mem_data      = wbuf;
  assign mem_be        = be;
  assign words_written = wcount;
  assign busy          = (state == FILL) || (state == WRITE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_decompress_word_writer.sv
// tb/tb_decompress_word_writer.sv - randomized self-checking bench for decompress_word_writer
module tb_decompress_word_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_last = 1'b0;
  logic        mem_ack = 1'b0;

  logic        start1, start2, ack1, ack2;
  logic        r1, we1, busy1, done1;
  logic [15:0] a1;
  logic [31:0] d1;
  logic [3:0]  be1;
  logic [16:0] ww1;
  logic        r2, we2, busy2, done2;
  logic [1:0]  a2;
  logic [31:0] d2;
  logic [3:0]  be2;
  logic [2:0]  ww2;

  logic        m_ready, m_we, m_busy, m_done;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_be;
  logic [16:0] m_ww;

  int total = 0;
  int bad = 0;

  logic [7:0]  byte_q[$];
  logic [15:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [3:0]  cap_be[$];
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_be[$];
  int          stall_bad;
  int          run_cycles;
  bit          timed_out;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign ack1   = mem_ack & ~sel;
  assign ack2   = mem_ack & sel;

  assign m_ready = sel ? r2 : r1;
  assign m_we    = sel ? we2 : we1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_done  = sel ? done2 : done1;
  assign m_addr  = sel ? {14'd0, a2} : a1;
  assign m_data  = sel ? d2 : d1;
  assign m_be    = sel ? be2 : be1;
  assign m_ww    = sel ? {14'd0, ww2} : ww1;

  decompress_word_writer #(.ADDR_WIDTH(16), .BASE_ADDR(16'd0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(r1), .mem_addr(a1), .mem_data(d1), .mem_be(be1),
    .mem_we(we1), .mem_ack(ack1), .words_written(ww1), .busy(busy1), .done(done1)
  );

  decompress_word_writer #(.ADDR_WIDTH(2), .BASE_ADDR(2'd3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(r2), .mem_addr(a2), .mem_data(d2), .mem_be(be2),
    .mem_we(we2), .mem_ack(ack2), .words_written(ww2), .busy(busy2), .done(done2)
  );

  // Reference: the byte stream cut into groups of four, each group one word at base+k.
  task automatic build_model(input int base, input int aw);
    int n;
    logic [31:0] w;
    logic [3:0]  m;
    exp_addr.delete(); exp_data.delete(); exp_be.delete();
    n = byte_q.size();
    for (int k = 0; k < (n + 3) / 4; k++) begin
      w = 32'd0;
      m = 4'd0;
      for (int j = 0; j < 4; j++) begin
        if (4 * k + j < n) begin
          w = w | (32'(byte_q[4 * k + j]) << (8 * j));
          m = m | 4'(1 << j);
        end
      end
      exp_addr.push_back(16'((base + k) % (1 << aw)));
      exp_data.push_back(w);
      exp_be.push_back(m);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: no end marker, 1: last rides on the final byte, 2: lone last after the bytes
  task automatic run_stream(input int mode, input int stall_min, input int stall_max,
                            input bit gaps, input bit start_noise);
    int  n, idx, stall_left;
    bit  pending, new_write;
    logic [15:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_be;
    n = byte_q.size();
    idx = 0; pending = 1'b0; new_write = 1'b1;
    s_addr = '0; s_data = '0; s_be = '0;
    stall_left = int'($urandom_range(stall_max, stall_min));
    cap_addr.delete(); cap_data.delete(); cap_be.delete();
    stall_bad = 0; run_cycles = 0; timed_out = 1'b0;
    forever begin
      if (pending) idx++;
      if (mode != 0 && m_done) break;
      if (mode == 0 && idx >= n && cap_data.size() == (n + 3) / 4 && !m_we) break;
      if (m_we) begin
        if (new_write) begin
          s_addr = m_addr; s_data = m_data; s_be = m_be; new_write = 1'b0;
        end else if (m_addr !== s_addr || m_data !== s_data || m_be !== s_be) begin
          stall_bad++;
        end
        if (m_ready) stall_bad++;
        if (stall_left > 0) begin
          mem_ack = 1'b0;
          stall_left--;
        end else begin
          mem_ack = 1'b1;
          cap_addr.push_back(m_addr); cap_data.push_back(m_data); cap_be.push_back(m_be);
          new_write = 1'b1;
          stall_left = int'($urandom_range(stall_max, stall_min));
        end
      end else begin
        mem_ack = 1'b0;
      end
      byte_in = 8'($urandom);
      if (mode == 2 && idx == n) begin
        byte_valid = 1'b0; byte_last = 1'b1;
      end else if (idx < n && !(gaps && $urandom_range(3) == 0)) begin
        byte_valid = 1'b1; byte_in = byte_q[idx]; byte_last = (mode == 1 && idx == n - 1);
      end else begin
        byte_valid = 1'b0; byte_last = 1'b0;
      end
      pending = m_ready && (byte_valid || byte_last);
      start = start_noise && ($urandom_range(7) == 0);
      run_cycles++;
      if (run_cycles > 600) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    apply_reset();
    total++;
    if ({r1, we1, a1, d1, be1, ww1, busy1, done1} !== '0) begin
      bad++; $display("FAIL reset_dut1: got %h, want 0", {r1, we1, a1, d1, be1, ww1, busy1, done1});
    end
    total++;
    if ({r2, we2, a2, d2, be2, ww2, busy2, done2} !== '0) begin
      bad++; $display("FAIL reset_dut2: got %h, want 0", {r2, we2, a2, d2, be2, ww2, busy2, done2});
    end
    byte_valid = 1'b1; byte_in = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if ({r1, busy1, we1, be1} !== 7'd0) begin
      bad++; $display("FAIL idle_ignores_bytes: got ready=%b busy=%b we=%b be=%b, want all 0", r1, busy1, we1, be1);
    end
  endtask

  task automatic test_full_word();
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_model(0, 16);
    run_stream(0, 0, 0, 1'b0, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 1) begin
      bad++; $display("FAIL full_count: got writes=%0d timeout=%0d, want 1 write", cap_data.size(), timed_out);
    end
    total++;
    if (cap_addr[0] !== 16'd0 || cap_data[0] !== 32'h44332211 || cap_be[0] !== 4'b1111) begin
      bad++; $display("FAIL full_word: got addr=%h data=%h be=%b, want 0000 44332211 1111", cap_addr[0], cap_data[0], cap_be[0]);
    end
    total++;
    if (m_ww !== 17'd1 || m_done !== 1'b0 || m_ready !== 1'b1) begin
      bad++; $display("FAIL full_status: got ww=%0d done=%b ready=%b, want 1 0 1", m_ww, m_done, m_ready);
    end
  endtask

  task automatic test_partial_flush();
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q = '{8'hAA, 8'hBB, 8'hCC};
    run_stream(1, 0, 0, 1'b0, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 1) begin
      bad++; $display("FAIL partial_count: got writes=%0d timeout=%0d, want 1 write", cap_data.size(), timed_out);
    end
    total++;
    if (cap_data[0] !== 32'h00CCBBAA || cap_be[0] !== 4'b0111) begin
      bad++; $display("FAIL partial_word: got data=%h be=%b, want 00ccbbaa 0111", cap_data[0], cap_be[0]);
    end
    total++;
    if (m_done !== 1'b1 || m_ww !== 17'd1 || m_busy !== 1'b0 || run_cycles != 4) begin
      bad++; $display("FAIL partial_done: got done=%b ww=%0d busy=%b cycles=%0d, want 1 1 0 4", m_done, m_ww, m_busy, run_cycles);
    end
  endtask

  task automatic test_lone_last();
    int extra_we;
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_stream(2, 0, 0, 1'b0, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 1 || cap_data[0] !== 32'h04030201 || cap_be[0] !== 4'b1111) begin
      bad++; $display("FAIL lone_word: got writes=%0d data=%h be=%b, want 1 04030201 1111", cap_data.size(), cap_data[0], cap_be[0]);
    end
    total++;
    if (m_done !== 1'b1 || m_ww !== 17'd1 || run_cycles != 6) begin
      bad++; $display("FAIL lone_done: got done=%b ww=%0d cycles=%0d, want 1 1 6", m_done, m_ww, run_cycles);
    end
    extra_we = 0;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_in = 8'(i); byte_last = (i == 3);
      @(negedge clk);
      if (m_we || m_ready || !m_done) extra_we++;
    end
    byte_valid = 1'b0; byte_last = 1'b0;
    total++;
    if (extra_we != 0 || m_ww !== 17'd1) begin
      bad++; $display("FAIL done_ignores_bytes: got bad_cycles=%0d ww=%0d, want 0 1", extra_we, m_ww);
    end
  endtask

  task automatic test_empty();
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q.delete();
    run_stream(2, 0, 0, 1'b0, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 0 || m_done !== 1'b1 || m_ww !== 17'd0 || run_cycles != 1) begin
      bad++; $display("FAIL empty_stream: got writes=%0d done=%b ww=%0d cycles=%0d, want 0 1 0 1", cap_data.size(), m_done, m_ww, run_cycles);
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    build_model(0, 16);
    run_stream(0, 5, 5, 1'b0, 1'b0);
    total++;
    if (timed_out || stall_bad != 0 || cap_data.size() != exp_data.size()) begin
      bad++; $display("FAIL stall_hold: got timeout=%0d unstable=%0d writes=%0d, want 0 0 %0d", timed_out, stall_bad, cap_data.size(), exp_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      total++;
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_be[i] !== exp_be[i]) begin
        bad++; $display("FAIL stall_word%0d: got %h %h %b, want %h %h %b", i, cap_addr[i], cap_data[i], cap_be[i], exp_addr[i], exp_data[i], exp_be[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    apply_reset(); do_start();
    byte_q.delete();
    for (int i = 0; i < 12; i++) byte_q.push_back(8'($urandom));
    build_model(0, 16);
    run_stream(1, 0, 0, 1'b0, 1'b0);
    total++;
    if (timed_out || run_cycles != 15 || m_ww !== 17'd3) begin
      bad++; $display("FAIL b2b_rate: got cycles=%0d ww=%0d timeout=%0d, want 15 3 0", run_cycles, m_ww, timed_out);
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      total++;
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_be[i] !== exp_be[i]) begin
        bad++; $display("FAIL b2b_word%0d: got %h %h %b, want %h %h %b", i, cap_addr[i], cap_data[i], cap_be[i], exp_addr[i], exp_data[i], exp_be[i]);
      end
    end
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    apply_reset(); do_start();
    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    build_model(3, 2);
    run_stream(0, 0, 2, 1'b1, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 2 || cap_addr[0] !== 16'd3 || cap_addr[1] !== 16'd0 || m_ww !== 17'd2) begin
      bad++; $display("FAIL wrap_addr: got writes=%0d addr0=%0d addr1=%0d ww=%0d, want 2 3 0 2", cap_data.size(), cap_addr[0], cap_addr[1], m_ww);
    end
    for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
      total++;
      if (cap_data[i] !== exp_data[i] || cap_be[i] !== exp_be[i]) begin
        bad++; $display("FAIL wrap_word%0d: got %h %b, want %h %b", i, cap_data[i], cap_be[i], exp_data[i], exp_be[i]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    apply_reset(); do_start();
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_in = 8'hE0 + 8'(i); mem_ack = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    total++;
    if (m_we !== 1'b1 || m_data !== 32'hE3E2E1E0) begin
      bad++; $display("FAIL mid_pre_write: got we=%b data=%h, want 1 e3e2e1e0", m_we, m_data);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({r1, we1, a1, d1, be1, ww1, busy1, done1} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got %h, want 0", {r1, we1, a1, d1, be1, ww1, busy1, done1});
    end
    do_start();
    byte_q = '{8'h9C, 8'h3D};
    run_stream(1, 0, 1, 1'b0, 1'b0);
    total++;
    if (timed_out || cap_data.size() != 1 || cap_addr[0] !== 16'd0 || cap_data[0] !== 32'h00003D9C
        || cap_be[0] !== 4'b0011 || m_ww !== 17'd1 || m_done !== 1'b1) begin
      bad++; $display("FAIL mid_restart: got writes=%0d addr=%h data=%h be=%b ww=%0d done=%b, want 1 0000 00003d9c 0011 1 1",
                      cap_data.size(), cap_addr[0], cap_data[0], cap_be[0], m_ww, m_done);
    end
  endtask

  task automatic test_random();
    int n, mode;
    sel = 1'b0;
    for (int it = 0; it < 30; it++) begin
      apply_reset(); do_start();
      n = int'($urandom_range(14, 0));
      byte_q.delete();
      for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
      if (n == 0) mode = 2;
      else if (n % 4 == 0) mode = int'($urandom_range(2, 0));
      else mode = int'($urandom_range(2, 1));
      build_model(0, 16);
      run_stream(mode, 0, 3, 1'b1, 1'b1);
      total++;
      if (timed_out || stall_bad != 0 || cap_data.size() != exp_data.size()
          || m_ww !== 17'(exp_data.size()) || m_done !== (mode != 0)) begin
        bad++; $display("FAIL rand%0d_status: got timeout=%0d unstable=%0d writes=%0d ww=%0d done=%b, want 0 0 %0d %0d %0d",
                        it, timed_out, stall_bad, cap_data.size(), m_ww, m_done, exp_data.size(), exp_data.size(), mode != 0);
      end
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
        total++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_be[i] !== exp_be[i]) begin
          bad++; $display("FAIL rand%0d_word%0d: got %h %h %b, want %h %h %b", it, i, cap_addr[i], cap_data[i], cap_be[i], exp_addr[i], exp_data[i], exp_be[i]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_word();
    test_partial_flush();
    test_lone_last();
    test_empty();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
